// File: rtl/tick_sched.sv
// Shared-timebase timeout scheduler: one free-running prescaler tick drives
// NCH one-shot countdowns, armed through a round-robin request/grant handshake.
module tick_sched #(
    parameter int unsigned NCH = 4,
    parameter logic [15:0] DIV = 16'h3333,
    parameter int unsigned CW  = 8
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [NCH-1:0]    arm_req,
    input  logic [NCH*CW-1:0] arm_cnt,
    input  logic [NCH-1:0]    cancel,
    output logic [NCH-1:0]    arm_gnt,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    expire,
    output logic              tick
);

    localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [15:0]    q_q, q_d;
    logic           tick_q, tick_d;
    logic           wrap;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] exp_q, exp_d;
    logic [NCH-1:0] elig;
    logic [CW-1:0]  rem_q [NCH];
    logic [CW-1:0]  rem_d [NCH];

    always_comb begin
        wrap   = (q_q == DIV);
        q_d    = wrap ? 16'd0 : q_q + 16'd1;
        tick_d = wrap;
    end

    // A channel still showing its grant pulse is excluded so it is never granted twice.
    always_comb begin : arb
        int unsigned   s;
        logic [PW-1:0] idx;
        logic          found;
        elig  = arm_req & ~busy_q & ~gnt_q;
        gnt_d = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        s     = 0;
        idx   = '0;
        for (int off = 0; off < int'(NCH); off++) begin
            s   = (int'(ptr_q) + off) % NCH;
            idx = PW'(s);
            if (!found && elig[idx]) begin
                gnt_d[idx] = 1'b1;
                ptr_d      = PW'((s + 1) % NCH);
                found      = 1'b1;
            end
        end
    end

    // Cancel outranks the final wrap; a freshly granted channel skips this edge's wrap.
    always_comb begin : chan
        logic [CW-1:0] cnt;
        busy_d = busy_q;
        exp_d  = '0;
        cnt    = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            rem_d[i] = rem_q[i];
            cnt      = arm_cnt[i*CW +: CW];
            if (gnt_d[i]) begin
                busy_d[i] = 1'b1;
                rem_d[i]  = (cnt == '0) ? CW'(1) : cnt;
            end else if (busy_q[i]) begin
                if (cancel[i]) begin
                    busy_d[i] = 1'b0;
                    rem_d[i]  = '0;
                end else if (wrap) begin
                    if (rem_q[i] == CW'(1)) begin
                        busy_d[i] = 1'b0;
                        exp_d[i]  = 1'b1;
                        rem_d[i]  = '0;
                    end else begin
                        rem_d[i] = rem_q[i] - CW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            q_q    <= '0;
            tick_q <= 1'b0;
            ptr_q  <= '0;
            gnt_q  <= '0;
            busy_q <= '0;
            exp_q  <= '0;
            for (int i = 0; i < int'(NCH); i++) rem_q[i] <= '0;
        end else begin
            q_q    <= q_d;
            tick_q <= tick_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            busy_q <= busy_d;
            exp_q  <= exp_d;
            for (int i = 0; i < int'(NCH); i++) rem_q[i] <= rem_d[i];
        end
    end

    assign arm_gnt = gnt_q;
    assign busy    = busy_q;
    assign expire  = exp_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_tick_sched.sv
// Directed bench for tick_sched with DIV=3 (tick every 4 edges, on edges 4, 8, 12, ...
// counted from reset release).
module tb_tick_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam logic [15:0] DIV = 16'd3;

    logic              clk = 1'b0;
    logic              rst_l = 1'b0;
    logic [NCH-1:0]    arm_req = '0;
    logic [NCH*CW-1:0] arm_cnt = '0;
    logic [NCH-1:0]    cancel = '0;
    logic [NCH-1:0]    arm_gnt, busy, expire;
    logic              tick;

    int checks = 0;
    int failures = 0;
    int e = 0;

    tick_sched #(.NCH(NCH), .DIV(DIV), .CW(CW)) dut (
        .clk     (clk),
        .rst_l   (rst_l),
        .arm_req (arm_req),
        .arm_cnt (arm_cnt),
        .cancel  (cancel),
        .arm_gnt (arm_gnt),
        .busy    (busy),
        .expire  (expire),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] b,
                           input logic [3:0] x, input logic t);
        chk({tag, ".gnt"},    8'(arm_gnt), 8'(g));
        chk({tag, ".busy"},   8'(busy),    8'(b));
        chk({tag, ".expire"}, 8'(expire),  8'(x));
        chk({tag, ".tick"},   8'(tick),    8'(t));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic step_to(input int t);
        while (e < t) step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_out("rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        @(negedge clk) rst_l = 1'b1;
        e = 0;

        // Free-running prescaler with no requests
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_out($sformatf("pre%0d", k), 4'b0000, 4'b0000, 4'b0000, (k % 4) == 0);
        end

        // All four request together, count 1 each; ch3 is granted on wrap edge 12
        arm_cnt = 32'h01010101;
        arm_req = 4'b1111;
        step(); chk_out("rr9",  4'b0001, 4'b0001, 4'b0000, 1'b0); arm_req[0] = 1'b0;
        step(); chk_out("rr10", 4'b0010, 4'b0011, 4'b0000, 1'b0); arm_req[1] = 1'b0;
        step(); chk_out("rr11", 4'b0100, 4'b0111, 4'b0000, 1'b0); arm_req[2] = 1'b0;
        step(); chk_out("rr12", 4'b1000, 4'b1000, 4'b0111, 1'b1); arm_req[3] = 1'b0;
        step_to(15); chk_out("wg15", 4'b0000, 4'b1000, 4'b0000, 1'b0);
        step();      chk_out("wg16", 4'b0000, 4'b0000, 4'b1000, 1'b1);

        // ch3 and ch0 together with ptr back at 0
        arm_cnt = 32'h02000002;
        arm_req = 4'b1001;
        step(); chk_out("rr17", 4'b0001, 4'b0001, 4'b0000, 1'b0); arm_req[0] = 1'b0;
        step(); chk_out("rr18", 4'b1000, 4'b1001, 4'b0000, 1'b0); arm_req[3] = 1'b0;

        // Cancel ch3 on its final wrap while ch0 expires normally
        step_to(23); chk_out("cx23", 4'b0000, 4'b1001, 4'b0000, 1'b0);
        cancel[3] = 1'b1;
        step();      chk_out("cx24", 4'b0000, 4'b0000, 4'b0001, 1'b1);
        cancel = '0;

        // ch1 re-requests while busy; second count 2 must expire at edge 36
        arm_cnt[15:8] = 8'd1;
        arm_req[1] = 1'b1;
        step(); chk_out("rq25", 4'b0010, 4'b0010, 4'b0000, 1'b0);
        arm_cnt[15:8] = 8'd2;
        step(); chk_out("rq26", 4'b0000, 4'b0010, 4'b0000, 1'b0);
        step(); chk_out("rq27", 4'b0000, 4'b0010, 4'b0000, 1'b0);
        step(); chk_out("rq28", 4'b0000, 4'b0000, 4'b0010, 1'b1);
        step(); chk_out("rq29", 4'b0010, 4'b0010, 4'b0000, 1'b0);
        arm_req[1] = 1'b0;
        step_to(35); chk_out("rq35", 4'b0000, 4'b0010, 4'b0000, 1'b0);
        step();      chk_out("rq36", 4'b0000, 4'b0000, 4'b0010, 1'b1);

        // Cancel on an idle channel does not block its grant
        arm_cnt[23:16] = 8'd1;
        arm_req[2] = 1'b1;
        cancel[2]  = 1'b1;
        step(); chk_out("ci37", 4'b0100, 4'b0100, 4'b0000, 1'b0);
        arm_req[2] = 1'b0;
        cancel[2]  = 1'b0;
        step_to(39); chk_out("ci39", 4'b0000, 4'b0100, 4'b0000, 1'b0);
        step();      chk_out("ci40", 4'b0000, 4'b0000, 4'b0100, 1'b1);

        // Three channels busy (ptr=3, so order 0,1,2), then async reset mid-cycle
        arm_cnt = 32'h05050505;
        arm_req = 4'b0111;
        step(); chk_out("mr41", 4'b0001, 4'b0001, 4'b0000, 1'b0); arm_req[0] = 1'b0;
        step(); chk_out("mr42", 4'b0010, 4'b0011, 4'b0000, 1'b0); arm_req[1] = 1'b0;
        step(); chk_out("mr43", 4'b0100, 4'b0111, 4'b0000, 1'b0); arm_req[2] = 1'b0;
        #3 rst_l = 1'b0;
        #1 chk_out("mrrst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_l = 1'b1;
        e = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk_out($sformatf("post%0d", k), 4'b0000, 4'b0000, 4'b0000, (k % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
# tick_sched

Shared-timebase timeout scheduler. A single free-running prescaler generates a periodic tick from `clk`. Up to NCH requesters each arm a one-shot countdown of N ticks through a round-robin-arbitrated request/grant handshake. Each channel reports busy status and a one-cycle expire pulse. The block sits beside the millisecond clock divider and lets several consumers share one timebase instead of instantiating private dividers.

## Interface
- `NCH`, 4: number of requester channels (2..8).
- `DIV`, 16'h3333: prescaler terminal count; tick period is DIV+1 clk cycles.
- `CW`, 8: countdown width in ticks.
- `clk` in 1: sole clock, all state on rising edge.
- `rst_l` in 1: asynchronous, active-low reset.
- `arm_req` in NCH: per-channel arm request, held by the requester until `arm_gnt`.
- `arm_cnt` in NCH*CW: per-channel tick count, channel i at bits [i*CW +: CW], held with `arm_req`.
- `cancel` in NCH: per-channel abort, sampled every edge.
- `arm_gnt` out NCH: one-hot, one-cycle grant pulse.
- `busy` out NCH: channel is counting.
- `expire` out NCH: one-cycle pulse when a channel's count completes.
- `tick` out 1: one-cycle pulse at each prescaler wrap.

## Operation
- **Prescaler:** 16-bit `q` counts 0..DIV.
  - At an edge where q==DIV: q←0 and `tick`←1.
  - Otherwise: q←q+1 and `tick`←0.
  - Internal `wrap` = (q==DIV), evaluated combinationally before the edge.
- **Arbitration:** eligible = `arm_req` & ~`busy` & ~`arm_gnt`.
  - Each edge, grant at most one eligible channel, chosen round-robin.
  - Search starts at `ptr`; after granting i, `ptr`←(i+1) mod NCH.
  - With no eligible channel, `ptr` holds and `arm_gnt`←0.
  - Requests from busy channels wait; they are never dropped or errored.
- **Load:** on the granting edge:
  - `arm_gnt[i]`←1, `busy[i]`←1.
  - rem[i]←`arm_cnt` slice, with 0 loaded as 1.
- **Countdown:** for each busy channel not granted this edge, on a `wrap` edge:
  - If rem==1: `busy`←0 and `expire`←1.
  - Otherwise: rem←rem−1.
  - `expire` is low on every other edge.
- **Cancel:** `cancel[i]` with `busy[i]`=1 sets `busy`←0 and rem←0 with no `expire`. Cancel on an idle channel has no effect and does not block its grant.
- **Simultaneous events:**
  - Grant and `wrap` on the same edge: the new channel is not decremented.
  - Cancel and final `wrap`: cancel wins, no `expire`.
  - Expire and a new `arm_req` on the same channel: the channel becomes eligible the following edge.
- **Reset** (async, any time including mid-countdown):
  - q=0, `ptr`=0, rem=0.
  - `busy`, `arm_gnt`, `expire`, and `tick` all 0.
  - Pending counts are discarded.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Grant latency: `arm_req` sampled at edge k with the channel eligible and winning arbitration → `arm_gnt` high during cycle k..k+1. The requester drops `arm_req` after seeing the grant. At edge k+1 the channel is already busy and `arm_gnt` is high, so there is no double grant.
- Expiry: a channel granted at edge k with count N asserts `expire` at the Nth `wrap` edge strictly after k. `expire` is coincident with `tick`.
- Elapsed time from grant to expire is between (N−1)(DIV+1)+1 and N(DIV+1) cycles.
- Worst-case grant wait with all channels requesting: NCH−1 cycles after the channel becomes idle.
- First `tick` after reset release: DIV+1 edges.

## Test plan
- **Prescaler** (DIV=3): release reset, then `tick` pulses every 4 cycles, first at edge 4, width 1 cycle. `busy`/`expire`/`arm_gnt` stay 0 with no requests.
- **Single arm** (DIV=3): ch0 `arm_cnt`=3, grant at edge k. `busy[0]` goes 1, `expire[0]` pulses at the 3rd wrap after k, `busy[0]` clears the same edge. `arm_cnt`=0 expires at the 1st wrap.
- **Round robin:** all 4 channels request at the same edge → grants on 4 consecutive edges in order 0,1,2,3. Then ch3 and ch0 request together → ch0 first (`ptr`=0).
- **Collisions:**
  - Grant on a wrap edge: no decrement, so `arm_cnt`=1 expires one tick later.
  - `cancel` on the final-wrap edge: `busy` clears, no `expire`.
- **Busy re-request:** ch1 requests while busy → no grant until the edge after `expire[1]`, then granted with the new count.
- **Reset mid-operation:** 3 channels busy, assert `rst_l`=0 asynchronously between edges. All outputs drop to 0 immediately. After release, `tick` restarts at DIV+1 and no stale `expire` occurs.
